// File: rtl/bus_mux_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : bus_mux_arb_if
//  Description : Signal bundle for the shared datapath bus multiplexer.
//                master : the side that owns the sources (drive requests,
//                         flattened source data, conflict clear) and
//                         observes the bus.
//                slave  : the multiplexer itself.
//                Ports  : src_out, src_data, conflict_clr (master -> slave)
//                         bus_out, bus_valid, grant_idx, conflict,
//                         conflict_sticky, conflict_count (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface bus_mux_arb_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 24,
    parameter int CNT_W   = 8,
    // A single source still needs a 1-bit index.
    parameter int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
);
    logic [NUM_SRC-1:0]       src_out;
    logic [NUM_SRC*WIDTH-1:0] src_data;
    logic                     conflict_clr;
    logic [WIDTH-1:0]         bus_out;
    logic                     bus_valid;
    logic [IDX_W-1:0]         grant_idx;
    logic                     conflict;
    logic                     conflict_sticky;
    logic [CNT_W-1:0]         conflict_count;

    modport master (
        output src_out, src_data, conflict_clr,
        input  bus_out, bus_valid, grant_idx, conflict, conflict_sticky,
               conflict_count
    );

    modport slave (
        input  src_out, src_data, conflict_clr,
        output bus_out, bus_valid, grant_idx, conflict, conflict_sticky,
               conflict_count
    );
endinterface
`default_nettype wire

// File: rtl/bus_mux_arb.sv
`default_nettype none
// ============================================================================
//  Module      : bus_mux_arb
//  Description : Fixed-priority datapath bus multiplexer. The highest-index
//                requesting source wins. When nobody drives, the bus holds
//                the last driven value. Simultaneous drivers are flagged per
//                cycle, latched in a sticky flag and counted (saturating).
//                Ports  : clk  - rising-edge clock
//                         clr  - synchronous active-high reset
//                         bus  - bus_mux_arb_if.slave (sources in, bus out)
//                REGISTERED=1 gives bus_out/bus_valid/grant_idx/conflict one
//                cycle after the request; REGISTERED=0 gives them in the
//                same cycle. The interface instance must be built with the
//                same WIDTH, NUM_SRC and CNT_W as this module.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_mux_arb #(
    parameter int WIDTH      = 32,
    parameter int NUM_SRC    = 24,
    parameter int REGISTERED = 1,
    parameter int CNT_W      = 8
) (
    input  wire logic    clk,
    input  wire logic    clr,
    bus_mux_arb_if.slave bus
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    // ------------------------------------------------------------------
    // Selection: ascending scan so the last (highest) requester wins.
    // A second requester seen after the first one marks a conflict.
    // ------------------------------------------------------------------
    logic             w_any;
    logic             w_multi;
    logic [IDX_W-1:0] w_sel;
    logic [WIDTH-1:0] w_sel_data;

    always_comb begin
        w_any      = 1'b0;
        w_multi    = 1'b0;
        w_sel      = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (bus.src_out[i]) begin
                w_multi    = w_multi | w_any;
                w_any      = 1'b1;
                w_sel      = IDX_W'(i);
                w_sel_data = bus.src_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // Hold value and last grant: updated only while someone drives.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_hold;
    logic [IDX_W-1:0] r_grant;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_hold  <= '0;
            r_grant <= '0;
        end else if (w_any) begin
            r_hold  <= w_sel_data;
            r_grant <= w_sel;
        end
    end

    // ------------------------------------------------------------------
    // Conflict tracking. conflict_clr beats a same-edge conflict.
    // ------------------------------------------------------------------
    logic             r_sticky;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (clr || bus.conflict_clr) begin
            r_sticky <= 1'b0;
            r_count  <= '0;
        end else if (w_multi) begin
            r_sticky <= 1'b1;
            if (r_count != {CNT_W{1'b1}}) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign bus.conflict_sticky = r_sticky;
    assign bus.conflict_count  = r_count;

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    generate
        if (REGISTERED != 0) begin : g_registered
            logic r_valid;
            logic r_conflict;

            always_ff @(posedge clk) begin
                if (clr) begin
                    r_valid    <= 1'b0;
                    r_conflict <= 1'b0;
                end else begin
                    r_valid    <= w_any;
                    r_conflict <= w_multi;
                end
            end

            // A registered "any ? selected : hold" is exactly the new hold
            // value, and the registered grant with hold is exactly r_grant,
            // so both outputs reuse those registers.
            assign bus.bus_out   = r_hold;
            assign bus.grant_idx = r_grant;
            assign bus.bus_valid = r_valid;
            assign bus.conflict  = r_conflict;
        end else begin : g_combinational
            // While clr is asserted the hold register is about to be
            // cleared, so the idle bus already shows the reset value.
            logic [WIDTH-1:0] w_hold_view;

            assign w_hold_view   = clr ? '0 : r_hold;
            assign bus.bus_out   = w_any ? w_sel_data : w_hold_view;
            assign bus.grant_idx = w_any ? w_sel : r_grant;
            assign bus.bus_valid = w_any;
            assign bus.conflict  = w_multi;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_bus_mux_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_mux_arb
//  Description : Self-checking bench for bus_mux_arb. Two instances share the
//                same stimulus: u_reg (REGISTERED=1, CNT_W=4) and
//                u_comb (REGISTERED=0, CNT_W=8). A reference model predicts
//                every output; registered expectations go through a queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_mux_arb;

    localparam int W  = 32;
    localparam int NS = 24;

    logic clk;
    logic clr;
    logic [NS-1:0]   tb_so;
    logic [NS*W-1:0] tb_sd;
    logic            tb_cclr;

    bus_mux_arb_if #(.WIDTH(W), .NUM_SRC(NS), .CNT_W(4)) ifr ();
    bus_mux_arb_if #(.WIDTH(W), .NUM_SRC(NS), .CNT_W(8)) ifc ();

    assign ifr.src_out      = tb_so;
    assign ifr.src_data     = tb_sd;
    assign ifr.conflict_clr = tb_cclr;
    assign ifc.src_out      = tb_so;
    assign ifc.src_data     = tb_sd;
    assign ifc.conflict_clr = tb_cclr;

    bus_mux_arb #(.WIDTH(W), .NUM_SRC(NS), .REGISTERED(1), .CNT_W(4)) u_reg (
        .clk (clk),
        .clr (clr),
        .bus (ifr.slave)
    );

    bus_mux_arb #(.WIDTH(W), .NUM_SRC(NS), .REGISTERED(0), .CNT_W(8)) u_comb (
        .clk (clk),
        .clr (clr),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] bus;
        logic        valid;
        logic [4:0]  grant;
        logic        conf;
        logic        sticky;
        logic [3:0]  cnt;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_hold   = '0;
    logic [4:0]  m_grant  = '0;
    logic        m_sticky = 1'b0;
    logic [3:0]  m_cnt4   = '0;
    logic [7:0]  m_cnt8   = '0;

    // One clock cycle: drive, check the combinational instance, predict the
    // registered instance, clock, then check the registered instance.
    task automatic step(input logic c, input logic cc, input logic [NS-1:0] so,
                        input logic [NS*W-1:0] sd);
        logic        any;
        int          nset;
        logic [4:0]  sel;
        logic [31:0] d;
        exp_t        e;
        exp_t        g;
        @(negedge clk);
        clr     = c;
        tb_cclr = cc;
        tb_so   = so;
        tb_sd   = sd;
        #1;
        any = 1'b0; nset = 0; sel = '0; d = '0;
        for (int i = NS - 1; i >= 0; i--) begin
            if (so[i]) begin
                if (!any) begin
                    any = 1'b1;
                    sel = 5'(i);
                    d   = sd[i*W +: W];
                end
                nset++;
            end
        end
        chk("comb_bus",    ifc.bus_out, any ? d : (c ? 32'h0 : m_hold));
        chk("comb_valid",  32'(ifc.bus_valid), 32'(any));
        chk("comb_grant",  32'(ifc.grant_idx), 32'(any ? sel : m_grant));
        chk("comb_conf",   32'(ifc.conflict), 32'(nset >= 2));
        chk("comb_sticky", 32'(ifc.conflict_sticky), 32'(m_sticky));
        chk("comb_cnt",    32'(ifc.conflict_count), 32'(m_cnt8));
        if (c) begin
            m_hold = '0; m_grant = '0; m_sticky = 1'b0; m_cnt4 = '0; m_cnt8 = '0;
        end else begin
            if (any) begin
                m_hold  = d;
                m_grant = sel;
            end
            if (cc) begin
                m_sticky = 1'b0; m_cnt4 = '0; m_cnt8 = '0;
            end else if (nset >= 2) begin
                m_sticky = 1'b1;
                if (m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 4'd1;
                if (m_cnt8 != 8'hFF) m_cnt8 = m_cnt8 + 8'd1;
            end
        end
        e.bus    = m_hold;
        e.valid  = c ? 1'b0 : any;
        e.grant  = m_grant;
        e.conf   = c ? 1'b0 : (nset >= 2);
        e.sticky = m_sticky;
        e.cnt    = m_cnt4;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            g = sb_q.pop_front();
            chk("reg_bus",    ifr.bus_out, g.bus);
            chk("reg_valid",  32'(ifr.bus_valid), 32'(g.valid));
            chk("reg_grant",  32'(ifr.grant_idx), 32'(g.grant));
            chk("reg_conf",   32'(ifr.conflict), 32'(g.conf));
            chk("reg_sticky", 32'(ifr.conflict_sticky), 32'(g.sticky));
            chk("reg_cnt",    32'(ifr.conflict_count), 32'(g.cnt));
        end
    endtask

    function automatic logic [NS*W-1:0] base_data();
        logic [NS*W-1:0] sd;
        for (int i = 0; i < NS; i++) sd[i*W +: W] = 32'h5000_0000 | 32'(i);
        return sd;
    endfunction

    function automatic logic [NS*W-1:0] rand_data();
        logic [NS*W-1:0] sd;
        for (int i = 0; i < NS; i++) sd[i*W +: W] = $urandom();
        return sd;
    endfunction

    function automatic logic [NS-1:0] rand_so();
        logic [NS-1:0] so;
        so = '0;
        case ($urandom_range(0, 3))
            0: so = '0;
            1: so[$urandom_range(0, NS-1)] = 1'b1;
            2: so = NS'($urandom());
            default: begin
                so[$urandom_range(0, NS-1)] = 1'b1;
                so[$urandom_range(0, NS-1)] = 1'b1;
            end
        endcase
        return so;
    endfunction

    // ---------------- directed table (expected = u_reg after the edge) ----
    typedef struct {
        logic        c;
        logic        cc;
        logic [23:0] so;
        int          ia;
        logic [31:0] va;
        int          ib;
        logic [31:0] vb;
        logic [31:0] e_bus;
        logic        e_valid;
        logic [4:0]  e_grant;
        logic        e_conf;
        logic        e_sticky;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [NS*W-1:0] sd;
        logic [NS-1:0]   so;
        logic            rc;

        tbl[0] = '{1'b1, 1'b0, 24'h000008,  3, 32'hDEADBEEF, -1, 32'h0,
                   32'h00000000, 1'b0, 5'd0,  1'b0, 1'b0, 4'd0};
        tbl[1] = '{1'b0, 1'b0, 24'h000020,  5, 32'h00001234, -1, 32'h0,
                   32'h00001234, 1'b1, 5'd5,  1'b0, 1'b0, 4'd0};
        tbl[2] = '{1'b0, 1'b0, 24'h000000, -1, 32'h0,        -1, 32'h0,
                   32'h00001234, 1'b0, 5'd5,  1'b0, 1'b0, 4'd0};
        tbl[3] = '{1'b0, 1'b0, 24'h800004,  2, 32'h11111111, 23, 32'hFFFFFFFC,
                   32'hFFFFFFFC, 1'b1, 5'd23, 1'b1, 1'b1, 4'd1};
        tbl[4] = '{1'b0, 1'b0, 24'h000000, -1, 32'h0,        -1, 32'h0,
                   32'hFFFFFFFC, 1'b0, 5'd23, 1'b0, 1'b1, 4'd1};
        tbl[5] = '{1'b0, 1'b1, 24'h800004,  2, 32'h11111111, 23, 32'hFFFFFFFC,
                   32'hFFFFFFFC, 1'b1, 5'd23, 1'b1, 1'b0, 4'd0};
        tbl[6] = '{1'b0, 1'b0, 24'h000001,  0, 32'hA5A5A5A5, -1, 32'h0,
                   32'hA5A5A5A5, 1'b1, 5'd0,  1'b0, 1'b0, 4'd0};
        tbl[7] = '{1'b1, 1'b0, 24'h000080, -1, 32'h0,        -1, 32'h0,
                   32'h00000000, 1'b0, 5'd0,  1'b0, 1'b0, 4'd0};
        tbl[8] = '{1'b0, 1'b0, 24'h000000, -1, 32'h0,        -1, 32'h0,
                   32'h00000000, 1'b0, 5'd0,  1'b0, 1'b0, 4'd0};

        clr = 1'b1; tb_cclr = 1'b0; tb_so = '0; tb_sd = '0;
        step(1'b1, 1'b0, '0, '0);
        step(1'b1, 1'b0, '0, '0);

        for (int k = 0; k < 9; k++) begin
            sd = base_data();
            if (tbl[k].ia >= 0) sd[tbl[k].ia*W +: W] = tbl[k].va;
            if (tbl[k].ib >= 0) sd[tbl[k].ib*W +: W] = tbl[k].vb;
            step(tbl[k].c, tbl[k].cc, tbl[k].so, sd);
            chk($sformatf("tbl%0d_bus", k),    ifr.bus_out, tbl[k].e_bus);
            chk($sformatf("tbl%0d_valid", k),  32'(ifr.bus_valid), 32'(tbl[k].e_valid));
            chk($sformatf("tbl%0d_grant", k),  32'(ifr.grant_idx), 32'(tbl[k].e_grant));
            chk($sformatf("tbl%0d_conf", k),   32'(ifr.conflict), 32'(tbl[k].e_conf));
            chk($sformatf("tbl%0d_sticky", k), 32'(ifr.conflict_sticky), 32'(tbl[k].e_sticky));
            chk($sformatf("tbl%0d_cnt", k),    32'(ifr.conflict_count), 32'(tbl[k].e_cnt));
        end

        // Saturation: counters start at 0 after the table's reset row.
        for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 24'h000012, rand_data());
        chk("sat_cnt4",   32'(ifr.conflict_count), 32'd15);
        chk("sat_cnt8",   32'(ifc.conflict_count), 32'd20);
        chk("sat_sticky", 32'(ifr.conflict_sticky), 32'd1);
        step(1'b0, 1'b1, 24'h000012, rand_data());
        chk("cclr_cnt4",   32'(ifr.conflict_count), 32'd0);
        chk("cclr_sticky", 32'(ifr.conflict_sticky), 32'd0);
        chk("cclr_cnt8",   32'(ifc.conflict_count), 32'd0);

        // Mid-operation reset with sources toggling.
        for (int k = 0; k < 60; k++) begin
            so = rand_so();
            rc = (k == 30);
            step(rc, 1'b0, so, rand_data());
            if (rc) begin
                chk("mid_rst_bus",    ifr.bus_out, 32'h0);
                chk("mid_rst_valid",  32'(ifr.bus_valid), 32'd0);
                chk("mid_rst_grant",  32'(ifr.grant_idx), 32'd0);
                chk("mid_rst_cnt",    32'(ifr.conflict_count), 32'd0);
                chk("mid_rst_sticky", 32'(ifr.conflict_sticky), 32'd0);
            end
        end

        // Long random run against the model.
        for (int k = 0; k < 1000; k++) begin
            step(1'b0, ($urandom_range(0, 15) == 0), rand_so(), rand_data());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_mux_arb.md
Name: bus_mux_arb

Overview:
- Parametrised successor to the datapath bus multiplexer.
- Selects one of NUM_SRC WIDTH-bit sources onto the shared datapath bus using fixed priority; the highest index wins.
- Adds sequential behaviour:
  - optional registered output stage;
  - bus-hold when no source drives;
  - registered grant index;
  - multi-driver conflict detection with a sticky flag and a saturating counter.
- Sits between the register file, special registers (HI/LO/Z/PC/MDR/IN port/C) and every bus consumer.

Parameters:
- WIDTH, 32, data width of each source and of the bus.
- NUM_SRC, 24, number of bus sources; index NUM_SRC-1 has highest priority.
- REGISTERED, 1, 1 = bus_out is registered (1-cycle latency); 0 = bus_out is combinational from the selected source.
- CNT_W, 8, width of the conflict counter.
- IDX_W, $clog2(NUM_SRC), width of grant_idx (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  synchronous active-high reset.
- src_out  input  NUM_SRC  per-source drive request; bit i = source i drives the bus.
- src_data  input  NUM_SRC*WIDTH  flattened source data; source i occupies bits [i*WIDTH +: WIDTH].
- conflict_clr  input  1  synchronous clear of conflict_sticky and conflict_count.
- bus_out  output  WIDTH  bus value.
- bus_valid  output  1  bus_out was driven by a source (not hold), aligned with bus_out.
- grant_idx  output  IDX_W  index of winning source, aligned with bus_out.
- conflict  output  1  ≥2 src_out bits were set in the cycle that produced the current bus_out.
- conflict_sticky  output  1  set on any conflict; cleared only by clr or conflict_clr.
- conflict_count  output  CNT_W  number of conflict cycles, saturating at all-ones.

Behaviour:
- Selection (combinational):
  - sel = highest i with src_out[i]=1; any = |src_out.
  - multi = popcount(src_out) ≥ 2.
- Hold register hold_q:
  - hold_q <= src_data[sel] on each edge where any=1; unchanged otherwise.
  - Present in both modes.
- REGISTERED=1:
  - bus_out <= any ? src_data[sel] : hold_q.
  - bus_valid <= any; grant_idx <= any ? sel : grant_idx (holds); conflict <= multi.
  - Latency is exactly 1 cycle from src_out/src_data to bus_out.
- REGISTERED=0:
  - bus_out = any ? src_data[sel] : hold_q; bus_valid = any; grant_idx = any ? sel : last registered grant; conflict = multi.
  - All combinational; same cycle.
- Conflict tracking (both modes, registered):
  - On edge with multi=1: conflict_sticky <= 1; conflict_count <= count+1 unless all-ones.
  - conflict_clr=1 clears both; same-edge priority: conflict_clr over multi (result 0 / 0).
- Reset (clr=1 at edge), clr has priority over everything:
  - hold_q=0, bus_out=0 (REGISTERED=1), bus_valid=0, grant_idx=0, conflict=0, conflict_sticky=0, conflict_count=0.
  - In REGISTERED=0, outputs during clr follow the combinational rule with hold_q=0.
- Boundaries:
  - No source asserted: bus keeps last driven value, never the default source.
  - Reset mid-transfer: value being driven is discarded; next cycle outputs are reset values.
  - Counter saturates at 2^CNT_W-1; no wrap.
  - NUM_SRC=1: grant_idx width is 1, always 0; conflict never asserts.
  - Out-of-range indices are never generated.

Test Plan:
- Reset: clr=1 with src_out[3]=1 and data 0xDEADBEEF -> next cycle bus_out=0, bus_valid=0, grant_idx=0, conflict_count=0.
- Single driver, REGISTERED=1: src_out=bit5, src5=0x00001234 at cycle N -> bus_out=0x00001234, grant_idx=5, bus_valid=1 at N+1. Then src_out=0 -> bus_out stays 0x00001234, bus_valid=0.
- Priority/conflict: src_out bits 2 and 23 set, src2=0x11111111, src23=0xFFFFFFFC -> bus_out=0xFFFFFFFC, grant_idx=23, conflict=1, conflict_sticky=1, conflict_count=1.
- Saturation: CNT_W=4, 20 consecutive conflict cycles -> conflict_count=15. conflict_clr and multi on the same edge -> count=0, sticky=0.
- REGISTERED=0: src_out=bit0, src0=0xA5A5A5A5 -> bus_out=0xA5A5A5A5 in the same cycle. Then src_out=0 -> bus_out=0xA5A5A5A5 (hold), bus_valid=0.
- Mid-operation reset: sources toggle randomly and clr is pulsed for 1 cycle -> all outputs reset the following cycle. Afterwards, bus_out matches a reference model that picks the highest-index driver and holds otherwise, for 1000 random cycles.
